// File: rtl/adder_sweep_checker.sv
// Exhaustive stimulus/compare engine for an external adder under test.
// Sweeps every {a,b,cin} vector, checks against a golden sum and records the first failure.
module adder_sweep_checker #(
   parameter int WIDTH         = 4,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic [WIDTH-1:0]   a_out,
   output logic [WIDTH-1:0]   b_out,
   output logic               cin_out,
   input  logic [WIDTH-1:0]   sum_in,
   input  logic               carry_in,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [2*WIDTH+1:0] err_count,
   output logic               fail_valid,
   output logic [WIDTH-1:0]   fail_a,
   output logic [WIDTH-1:0]   fail_b,
   output logic               fail_cin
);

   localparam int VW = 2*WIDTH+1;
   localparam int CW = 2*WIDTH+2;

   typedef enum logic [2:0] {
      IDLE,
      APPLY,
      SETTLE,
      CHECK,
      DONE
   } state_t;

   state_t          state, state_nx;
   logic [VW-1:0]   v;
   logic [3:0]      settle_cnt;
   logic [WIDTH:0]  expected;
   logic            mismatch;
   logic            last_vec;
   logic [CW-1:0]   err_nx;

   // v is the only operand state, so the operand outputs are register slices
   assign cin_out = v[0];
   assign b_out   = v[WIDTH:1];
   assign a_out   = v[2*WIDTH:WIDTH+1];

   assign expected = {1'b0, a_out} + {1'b0, b_out} + {{WIDTH{1'b0}}, cin_out};
   assign mismatch = ({carry_in, sum_in} != expected);
   assign last_vec = (v == {VW{1'b1}});
   assign err_nx   = err_count + {{(CW-1){1'b0}}, mismatch};

   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE: if (start) state_nx = APPLY;
         APPLY:      state_nx = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
         SETTLE:     if (settle_cnt <= 4'd1) state_nx = CHECK;
         CHECK:      state_nx = last_vec ? DONE : APPLY;
         default:    state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v          <= '0;
         settle_cnt <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= '0;
         fail_valid <= 1'b0;
         fail_a     <= '0;
         fail_b     <= '0;
         fail_cin   <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  v          <= '0;
                  err_count  <= '0;
                  fail_valid <= 1'b0;
                  fail_a     <= '0;
                  fail_b     <= '0;
                  fail_cin   <= 1'b0;
                  done       <= 1'b0;
                  pass       <= 1'b0;
                  busy       <= 1'b1;
               end
            end
            APPLY: settle_cnt <= 4'(SETTLE_CYCLES);
            SETTLE: settle_cnt <= settle_cnt - 4'd1;
            CHECK: begin
               err_count <= err_nx;
               // only the first failing vector of a sweep is kept
               if (mismatch && !fail_valid) begin
                  fail_valid <= 1'b1;
                  fail_a     <= a_out;
                  fail_b     <= b_out;
                  fail_cin   <= cin_out;
               end
               if (last_vec) begin
                  busy <= 1'b0;
                  done <= 1'b1;
                  pass <= (err_nx == '0);
               end else begin
                  v <= v + {{(VW-1){1'b0}}, 1'b1};
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_adder_sweep_checker.sv
// Scoreboard bench: three checker instances against comb, faulty and 2-cycle registered adders.
module tb_adder_sweep_checker;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   typedef struct {
      int  err;
      bit  pass;
      bit  fv;
      int  fa;
      int  fb;
      int  fc;
      bit  gt0;
      bit  chk_cyc;
      int  c0;
      int  len;
   } exp_t;

   exp_t q0[$];
   exp_t q2[$];
   exp_t qz[$];

   // ---------------- instance 0: SETTLE=1, combinational adder with fault modes
   logic       start0 = 0, start2 = 0, startz = 0;
   logic [3:0] a0, b0, s0, fa0, fb0;
   logic       c0, k0, busy0, done0, pass0, fv0, fc0;
   logic [9:0] err0;
   int         mode = 0;
   logic [4:0] t0;

   always_comb begin
      t0 = {1'b0, a0} + {1'b0, b0} + {4'd0, c0};
      if (mode == 1) t0[4] = 1'b0;
      if (mode == 2) t0[0] = ~t0[0];
   end
   assign s0 = t0[3:0];
   assign k0 = t0[4];

   adder_sweep_checker #(.WIDTH(4), .SETTLE_CYCLES(1)) dut0 (
      .clk(clk), .rst(rst), .start(start0),
      .a_out(a0), .b_out(b0), .cin_out(c0), .sum_in(s0), .carry_in(k0),
      .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
      .fail_valid(fv0), .fail_a(fa0), .fail_b(fb0), .fail_cin(fc0));

   // ---------------- instances 2 and z: 2-cycle registered adder, SETTLE=2 and SETTLE=0
   logic [3:0] a2, b2, fa2, fb2, az, bz, faz, fbz;
   logic       c2, busy2, done2, pass2, fv2, fc2, cz, busyz, donez, passz, fvz, fcz;
   logic [9:0] err2, errz;
   logic [4:0] p2a, p2b, pza, pzb;

   always @(posedge clk) begin
      if (rst) begin
         p2a <= '0; p2b <= '0; pza <= '0; pzb <= '0;
      end else begin
         p2a <= {1'b0, a2} + {1'b0, b2} + {4'd0, c2};
         p2b <= p2a;
         pza <= {1'b0, az} + {1'b0, bz} + {4'd0, cz};
         pzb <= pza;
      end
   end

   adder_sweep_checker #(.WIDTH(4), .SETTLE_CYCLES(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2),
      .a_out(a2), .b_out(b2), .cin_out(c2), .sum_in(p2b[3:0]), .carry_in(p2b[4]),
      .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
      .fail_valid(fv2), .fail_a(fa2), .fail_b(fb2), .fail_cin(fc2));

   adder_sweep_checker #(.WIDTH(4), .SETTLE_CYCLES(0)) dutz (
      .clk(clk), .rst(rst), .start(startz),
      .a_out(az), .b_out(bz), .cin_out(cz), .sum_in(pzb[3:0]), .carry_in(pzb[4]),
      .busy(busyz), .done(donez), .pass(passz), .err_count(errz),
      .fail_valid(fvz), .fail_a(faz), .fail_b(fbz), .fail_cin(fcz));

   // ---------------- monitor: compares on each rising done
   task automatic score(input string tag, input exp_t e, input int err, input bit p,
                        input bit fv, input int fa, input int fb, input int fc, input bit bsy);
      if (e.gt0) check({tag, "_err_nonzero"}, int'(err != 0), 1);
      else       check({tag, "_err"}, err, e.err);
      check({tag, "_pass"}, p, e.pass);
      check({tag, "_busy"}, bsy, 0);
      check({tag, "_fail_valid"}, fv, e.fv);
      check({tag, "_fail_a"}, fa, e.fa);
      check({tag, "_fail_b"}, fb, e.fb);
      check({tag, "_fail_cin"}, fc, e.fc);
      if (e.chk_cyc) check({tag, "_cycles"}, cyc - e.c0, e.len);
   endtask

   logic pd0 = 0, pd2 = 0, pdz = 0;
   always @(negedge clk) begin
      exp_t e;
      if (done0 && !pd0) begin
         if (q0.size() == 0) check("dut0_unexpected_done", 1, 0);
         else begin
            e = q0.pop_front();
            score("dut0", e, int'(err0), pass0, fv0, int'(fa0), int'(fb0), int'(fc0), busy0);
         end
      end
      if (done2 && !pd2) begin
         if (q2.size() == 0) check("dut2_unexpected_done", 1, 0);
         else begin
            e = q2.pop_front();
            score("dut2", e, int'(err2), pass2, fv2, int'(fa2), int'(fb2), int'(fc2), busy2);
         end
      end
      if (donez && !pdz) begin
         if (qz.size() == 0) check("dutz_unexpected_done", 1, 0);
         else begin
            e = qz.pop_front();
            score("dutz", e, int'(errz), passz, fvz, int'(faz), int'(fbz), int'(fcz), busyz);
         end
      end
      pd0 <= done0; pd2 <= done2; pdz <= donez;
   end

   // ---------------- stimulus
   function automatic exp_t mk(int err, bit p, bit fv, int fa, int fb, int fc, bit gt0, int len);
      exp_t e;
      e.err = err; e.pass = p; e.fv = fv; e.fa = fa; e.fb = fb; e.fc = fc;
      e.gt0 = gt0; e.chk_cyc = (len != 0); e.c0 = 0; e.len = len;
      return e;
   endfunction

   task automatic pulse_start0(input exp_t e);
      @(negedge clk) start0 = 1'b1;
      @(negedge clk);
      e.c0 = cyc;
      q0.push_back(e);
      start0 = 1'b0;
   endtask

   task automatic wait_done0(input string name);
      int n = 0;
      while (!done0 && n < 4000) begin
         @(negedge clk);
         n++;
      end
      if (!done0) check({name, "_timeout"}, 0, 1);
      @(negedge clk);
   endtask

   task automatic check_zero0(input string tag);
      check({tag, "_operands"}, int'({a0, b0, c0}), 0);
      check({tag, "_flags"}, int'({busy0, done0, pass0, fv0}), 0);
      check({tag, "_err"}, int'(err0), 0);
      check({tag, "_fail_vec"}, int'({fa0, fb0, fc0}), 0);
   endtask

   initial begin
      exp_t e;
      int n;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_zero0("reset");
      repeat (3) @(negedge clk);
      check("idle_static", int'({busy0, done0, a0, b0, c0}), 0);

      // correct adder, sweep length 512*3
      mode = 0;
      pulse_start0(mk(0, 1, 0, 0, 0, 0, 0, 1536));
      check("start_busy", busy0, 1);
      check("start_vec0", int'({a0, b0, c0}), 0);
      wait_done0("good");

      // carry stuck at 0: first carry-producing vector in sweep order is 0+15+1
      mode = 1;
      pulse_start0(mk(256, 0, 1, 0, 15, 1, 0, 1536));
      wait_done0("carry0");

      // sum bit 0 inverted: every vector fails
      mode = 2;
      pulse_start0(mk(512, 0, 1, 0, 0, 0, 0, 1536));
      wait_done0("sum0inv");

      // restart from DONE clears results; a start while busy must not disturb the sweep
      mode = 0;
      pulse_start0(mk(0, 1, 0, 0, 0, 0, 0, 1536));
      check("restart_done_clr", done0, 0);
      check("restart_pass_clr", pass0, 0);
      check("restart_err_clr", int'(err0), 0);
      check("restart_fv_clr", fv0, 0);
      repeat (100) @(negedge clk);
      start0 = 1'b1;
      @(negedge clk) start0 = 1'b0;
      check("busy_start_ignored", busy0, 1);
      check("busy_start_no_rewind", int'(a0 != 0), 1);
      wait_done0("restart");

      // reset mid-sweep discards the partial result
      pulse_start0(mk(0, 1, 0, 0, 0, 0, 0, 1536));
      repeat (300) @(negedge clk);
      q0.delete();
      rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      check_zero0("midrst");
      pulse_start0(mk(0, 1, 0, 0, 0, 0, 0, 1536));
      wait_done0("after_rst");

      // registered adder: SETTLE=2 passes; SETTLE=0 compares one vector late, first fail at v=1
      e = mk(0, 1, 0, 0, 0, 0, 0, 2048);
      @(negedge clk) begin start2 = 1'b1; startz = 1'b1; end
      @(negedge clk);
      e.c0 = cyc;
      q2.push_back(e);
      e = mk(0, 0, 1, 0, 0, 1, 1, 1024);
      e.c0 = cyc;
      qz.push_back(e);
      start2 = 1'b0; startz = 1'b0;
      n = 0;
      while (!(done2 && donez) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (!(done2 && donez)) check("latency_timeout", 0, 1);
      repeat (2) @(negedge clk);

      check("queues_drained", q0.size() + q2.size() + qz.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
